// File: rtl/axis_crosspoint_pkt.sv
// AXI4-Stream S_COUNT x M_COUNT crosspoint with registered outputs.
// Per-output source selects are only latched between frames.
module axis_crosspoint_pkt #(
    parameter int S_COUNT         = 4,
    parameter int M_COUNT         = 4,
    parameter int DATA_WIDTH      = 8,
    parameter bit KEEP_ENABLE     = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH      = ((DATA_WIDTH + 7) / 8),
    parameter bit LAST_ENABLE     = 1,
    parameter bit USER_ENABLE     = 1,
    parameter int USER_WIDTH      = 1,
    parameter bit DROP_UNSELECTED = 0,
    localparam int SEL_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,
    output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [M_COUNT-1:0]               m_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_axis_tready,
    output logic [M_COUNT-1:0]               m_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
    input  logic [M_COUNT*SEL_W-1:0]         select,
    input  logic [M_COUNT-1:0]               select_en,
    output logic [M_COUNT-1:0]               busy
);

    logic [M_COUNT-1:0]    active_q, active_d;
    logic [M_COUNT-1:0]    en_q, en_d;
    logic [M_COUNT-1:0]    valid_q, valid_d;
    logic [M_COUNT-1:0]    last_q, last_d;
    logic [SEL_W-1:0]      src_q  [M_COUNT];
    logic [SEL_W-1:0]      src_d  [M_COUNT];
    logic [DATA_WIDTH-1:0] data_q [M_COUNT];
    logic [DATA_WIDTH-1:0] data_d [M_COUNT];
    logic [KEEP_WIDTH-1:0] keep_q [M_COUNT];
    logic [KEEP_WIDTH-1:0] keep_d [M_COUNT];
    logic [USER_WIDTH-1:0] user_q [M_COUNT];
    logic [USER_WIDTH-1:0] user_d [M_COUNT];

    logic [S_COUNT-1:0]    conn [M_COUNT];
    logic [M_COUNT-1:0]    can_accept;
    logic [M_COUNT-1:0]    load;
    logic [M_COUNT-1:0]    in_last;
    logic [S_COUNT-1:0]    hit;
    logic [S_COUNT-1:0]    s_ready;

    // Out-of-range sources never match any input, so they act as disabled.
    always_comb begin
        for (int k = 0; k < M_COUNT; k++) begin
            conn[k] = '0;
            for (int j = 0; j < S_COUNT; j++) begin
                conn[k][j] = en_q[k] && (src_q[k] == SEL_W'(j));
            end
        end
    end

    always_comb begin
        can_accept = ~valid_q | m_axis_tready;
    end

    always_comb begin
        hit     = '0;
        s_ready = '1;
        for (int k = 0; k < M_COUNT; k++) begin
            for (int j = 0; j < S_COUNT; j++) begin
                if (conn[k][j]) begin
                    hit[j] = 1'b1;
                    if (!can_accept[k]) begin
                        s_ready[j] = 1'b0;
                    end
                end
            end
        end
        for (int j = 0; j < S_COUNT; j++) begin
            if (!hit[j]) begin
                s_ready[j] = DROP_UNSELECTED;
            end
        end
    end

    always_comb begin
        active_d = active_q;
        en_d     = en_q;
        valid_d  = valid_q & ~m_axis_tready;
        last_d   = last_q;
        load     = '0;
        in_last  = '0;
        src_d    = src_q;
        data_d   = data_q;
        keep_d   = keep_q;
        user_d   = user_q;
        for (int k = 0; k < M_COUNT; k++) begin
            for (int j = 0; j < S_COUNT; j++) begin
                if (conn[k][j] && s_axis_tvalid[j] && s_ready[j]) begin
                    load[k]    = 1'b1;
                    in_last[k] = LAST_ENABLE ? s_axis_tlast[j] : 1'b1;
                    data_d[k]  = s_axis_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                    keep_d[k]  = s_axis_tkeep[j*KEEP_WIDTH +: KEEP_WIDTH];
                    user_d[k]  = s_axis_tuser[j*USER_WIDTH +: USER_WIDTH];
                end
            end
            if (load[k]) begin
                valid_d[k] = 1'b1;
                last_d[k]  = in_last[k];
                if (LAST_ENABLE) begin
                    active_d[k] = !in_last[k];
                end
            end
            // A beat that opens a frame locks the current source.
            if (!active_q[k] && !(load[k] && !in_last[k])) begin
                src_d[k] = select[k*SEL_W +: SEL_W];
                en_d[k]  = select_en[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            en_q     <= '0;
            valid_q  <= '0;
            src_q    <= '{default: '0};
        end else begin
            active_q <= active_d;
            en_q     <= en_d;
            valid_q  <= valid_d;
            src_q    <= src_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
        user_q <= user_d;
        last_q <= last_d;
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tkeep = '0;
        m_axis_tuser = '0;
        m_axis_tlast = '0;
        for (int k = 0; k < M_COUNT; k++) begin
            m_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH] = data_q[k];
            m_axis_tkeep[k*KEEP_WIDTH +: KEEP_WIDTH] =
                KEEP_ENABLE ? keep_q[k] : {KEEP_WIDTH{1'b1}};
            m_axis_tuser[k*USER_WIDTH +: USER_WIDTH] =
                USER_ENABLE ? user_q[k] : {USER_WIDTH{1'b0}};
            m_axis_tlast[k] = LAST_ENABLE ? last_q[k] : 1'b1;
        end
    end

    assign m_axis_tvalid = valid_q;
    assign s_axis_tready = s_ready;
    assign busy          = active_q;

endmodule

// File: tb/tb_axis_crosspoint_pkt.sv
// Directed and randomized bench for axis_crosspoint_pkt.
// Stress frames carry {source, frame id, beat} so outputs can be audited.
module tb_axis_crosspoint_pkt;

    localparam int DW = 24;
    localparam int KW = 3;
    localparam int NF = 16384;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*DW-1:0] s_tdata;
    logic [4*KW-1:0] s_tkeep;
    logic [3:0]      s_tvalid, s_tlast, s_tuser;
    logic [3:0]      s_tready, d_tready;
    logic [4*DW-1:0] m_tdata, d_tdata;
    logic [4*KW-1:0] m_tkeep, d_tkeep;
    logic [3:0]      m_tvalid, m_tlast, m_tuser, busy;
    logic [3:0]      d_tvalid, d_tlast, d_tuser, d_busy;
    logic [3:0]      m_tready;
    logic [7:0]      sel;
    logic [3:0]      sel_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_crosspoint_pkt #(.DATA_WIDTH(DW), .DROP_UNSELECTED(0)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .select(sel), .select_en(sel_en), .busy(busy)
    );

    axis_crosspoint_pkt #(.DATA_WIDTH(DW), .DROP_UNSELECTED(1)) dut_d (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(d_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(d_tdata), .m_axis_tkeep(d_tkeep),
        .m_axis_tvalid(d_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(d_tlast), .m_axis_tuser(d_tuser),
        .select(sel), .select_en(sel_en), .busy(d_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] mkeep(input logic [DW-1:0] d);
        return d[2:0] ^ 3'b101;
    endfunction

    task automatic set_in(input int j, input logic [DW-1:0] d,
                          input logic l, input logic v);
        s_tdata[j*DW +: DW] = d;
        s_tkeep[j*KW +: KW] = mkeep(d);
        s_tuser[j]  = ^d;
        s_tlast[j]  = l;
        s_tvalid[j] = v;
    endtask

    function automatic logic [DW-1:0] enc(input int j, input int f,
                                          input int b);
        return {2'(j), 19'(f), 3'(b)};
    endfunction

    // Broadcast capture
    logic [DW-1:0] q0[$], q1[$];

    task automatic capture();
        if (m_tvalid[0] && m_tready[0]) q0.push_back(m_tdata[0 +: DW]);
        if (m_tvalid[1] && m_tready[1]) q1.push_back(m_tdata[DW +: DW]);
    endtask

    // Stress reference state
    int  nb[4], fl[4], fid[4];
    int  acc_len[4][NF];
    bit  seen[4][NF];
    bit  inf[4];
    int  csrc[4], cfid[4], cb[4];
    int  lastf[4][4];
    int  cur_sel[4];
    bit  cur_en[4];

    task automatic out_beat(input int k);
        logic [DW-1:0] d;
        int j, f, b;
        d = m_tdata[k*DW +: DW];
        j = int'(d[23:22]);
        f = int'(d[21:3]);
        b = int'(d[2:0]);
        check("st_keep", 32'(m_tkeep[k*KW +: KW]), 32'(mkeep(d)));
        check("st_user", 32'(m_tuser[k]), 32'(^d));
        if (!inf[k]) begin
            check("st_frame_start", {30'd0, b == 0, f > lastf[k][j]}, 32'd3);
            inf[k]  = 1'b1;
            csrc[k] = j;
            cfid[k] = f;
        end else begin
            check("st_frame_cont", 32'({2'(j), 19'(f), 3'(b)}),
                  32'({2'(csrc[k]), 19'(cfid[k]), 3'(cb[k] + 1)}));
        end
        cb[k] = b;
        if (m_tlast[k]) begin
            check("st_frame_len", 32'(b + 1), 32'(acc_len[j][f]));
            lastf[k][j] = f;
            seen[j][f]  = 1'b1;
            inf[k]      = 1'b0;
        end
    endtask

    task automatic stress_cycle(input bit drain);
        logic [3:0] block;
        int nj;
        bit ne, v;
        block = '0;
        for (int k = 0; k < 4; k++) begin
            m_tready[k] = drain ? 1'b1 : ($urandom % 4 != 0);
            nj = int'($urandom % 4);
            ne = ($urandom % 5 != 0);
            if (!drain && !busy[k] && ($urandom % 40 == 0) && nb[nj] == 0) begin
                if (cur_en[k]) block[cur_sel[k]] = 1'b1;
                block[nj] = 1'b1;
                sel[k*2 +: 2] = 2'(nj);
                sel_en[k] = ne;
                cur_sel[k] = nj;
                cur_en[k]  = ne;
            end
        end
        for (int j = 0; j < 4; j++) begin
            v = drain ? (nb[j] != 0) : (($urandom % 10 < 7) && !block[j]);
            set_in(j, enc(j, fid[j], nb[j]), nb[j] == fl[j] - 1, v);
        end
        #1;
        for (int j = 0; j < 4; j++) begin
            if (s_tvalid[j] && s_tready[j]) begin
                if (nb[j] == fl[j] - 1) begin
                    if (fid[j] < NF) acc_len[j][fid[j]] = fl[j];
                    fid[j]++;
                    nb[j] = 0;
                    fl[j] = int'($urandom_range(1, 4));
                end else begin
                    nb[j]++;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (m_tvalid[k] && m_tready[k]) out_beat(k);
        end
        @(negedge clk);
    endtask

    initial begin
        logic exp_r, ov1;
        int idx, missing, total;
        logic [3:0] inf_v;

        rst = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        m_tready = '1; sel = '0; sel_en = '0;
        repeat (2) @(negedge clk);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_drop_s_tready", 32'(d_tready), 32'hf);
        rst = 1'b0;

        // Unicast out0 <- in1
        sel[1:0] = 2'd1; sel_en = 4'b0001;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_in(1, DW'('h11 + i), i == 3, 1'b1);
            #1 check("uni_s_tready", 32'(s_tready[1]), 32'd1);
            @(negedge clk);
            check("uni_valid", 32'(m_tvalid[0]), 32'd1);
            check("uni_data", 32'(m_tdata[0 +: DW]), 32'('h11 + i));
            check("uni_keep", 32'(m_tkeep[0 +: KW]), 32'(mkeep(DW'('h11 + i))));
            check("uni_last", 32'(m_tlast[0]), 32'(i == 3));
            check("uni_busy", 32'(busy[0]), 32'(i != 3));
        end
        set_in(1, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("uni_idle", 32'(m_tvalid[0]), 32'd0);

        // Deferred switch from in1 to in2
        set_in(1, DW'('h21), 1'b0, 1'b1);
        set_in(2, DW'('h31), 1'b0, 1'b1);
        #1 check("sw_s_tready", 32'(s_tready), 32'b0010);
        @(negedge clk);
        check("sw_d21", 32'(m_tdata[0 +: DW]), 32'h21);
        set_in(1, DW'('h22), 1'b0, 1'b1);
        @(negedge clk);
        check("sw_d22", 32'(m_tdata[0 +: DW]), 32'h22);
        set_in(1, DW'('h23), 1'b0, 1'b1);
        sel[1:0] = 2'd2;
        @(negedge clk);
        check("sw_d23", 32'(m_tdata[0 +: DW]), 32'h23);
        check("sw_busy_mid", 32'(busy[0]), 32'd1);
        set_in(1, DW'('h24), 1'b1, 1'b1);
        @(negedge clk);
        check("sw_d24", 32'({m_tlast[0], m_tdata[0 +: DW]}), 32'h1000024);
        check("sw_busy_fall", 32'(busy[0]), 32'd0);
        set_in(1, '0, 1'b0, 1'b0);
        #1 check("sw_in2_stalled", 32'(s_tready[2]), 32'd0);
        @(negedge clk);
        #1 check("sw_in2_ready", 32'(s_tready[2]), 32'd1);
        @(negedge clk);
        check("sw_d31", 32'({m_tvalid[0], m_tdata[0 +: DW]}), 32'h1000031);
        set_in(2, DW'('h32), 1'b1, 1'b1);
        @(negedge clk);
        check("sw_d32", 32'({m_tlast[0], m_tdata[0 +: DW]}), 32'h1000032);
        set_in(2, '0, 1'b0, 1'b0);

        // Broadcast in0 -> out0, out1 with out1 backpressure
        sel = '0; sel_en = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        idx = 0; ov1 = 1'b0;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            m_tready[1] = (c % 2 == 0);
            set_in(0, DW'('h41 + idx), idx == 5, 1'b1);
            #1;
            exp_r = !ov1 || m_tready[1];
            check("bc_s_tready", 32'(s_tready[0]), 32'(exp_r));
            capture();
            if (exp_r) idx++;
            ov1 = exp_r ? 1'b1 : (ov1 && !m_tready[1]);
            @(negedge clk);
        end
        set_in(0, '0, 1'b0, 1'b0);
        m_tready = '1;
        repeat (3) begin
            #1 capture();
            @(negedge clk);
        end
        check("bc_count0", 32'(q0.size()), 32'd6);
        check("bc_count1", 32'(q1.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < q0.size()) check("bc_beat0", 32'(q0[i]), 32'('h41 + i));
            if (i < q1.size()) check("bc_beat1", 32'(q1[i]), 32'('h41 + i));
        end

        // Unselected input 3
        set_in(3, DW'('h77), 1'b1, 1'b1);
        #1;
        check("drop_s_tready3", 32'(d_tready[3]), 32'd1);
        check("stall_s_tready3", 32'(s_tready[3]), 32'd0);
        @(negedge clk);
        check("drop_no_output", 32'(d_tvalid), 32'd0);
        check("stall_no_output", 32'(m_tvalid), 32'd0);
        set_in(3, '0, 1'b0, 1'b0);

        // Reset mid-frame
        sel[1:0] = 2'd1; sel_en = 4'b0001;
        @(negedge clk);
        set_in(1, DW'('h51), 1'b0, 1'b1);
        @(negedge clk);
        set_in(1, DW'('h52), 1'b0, 1'b1);
        @(negedge clk);
        check("rmf_busy_before", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        set_in(1, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("rmf_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rmf_busy", 32'(busy), 32'd0);
        sel[1:0] = 2'd3; sel_en = 4'b0001;
        set_in(3, DW'('h61), 1'b1, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rmf_latch_ready", 32'(s_tready[3]), 32'd1);
        check("rmf_no_partial", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        check("rmf_new_beat",
              32'({m_tvalid[0], m_tlast[0], m_tdata[0 +: DW]}), 32'h3000061);
        set_in(3, '0, 1'b0, 1'b0);

        // Random stress
        rst = 1'b1; sel = '0; sel_en = '0; m_tready = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            nb[j] = 0; fid[j] = 0; fl[j] = int'($urandom_range(1, 4));
            inf[j] = 1'b0; cur_sel[j] = 0; cur_en[j] = 1'b0;
            csrc[j] = 0; cfid[j] = 0; cb[j] = 0;
            for (int s = 0; s < 4; s++) lastf[j][s] = -1;
        end
        for (int c = 0; c < 10000; c++) stress_cycle(1'b0);
        for (int c = 0; c < 60; c++) stress_cycle(1'b1);

        missing = 0; total = 0;
        for (int j = 0; j < 4; j++) begin
            for (int f = 0; f < fid[j] && f < NF; f++) begin
                total++;
                if (!seen[j][f]) missing++;
            end
        end
        inf_v = {inf[3], inf[2], inf[1], inf[0]};
        check("st_all_delivered", 32'(missing), 32'd0);
        check("st_outputs_closed", 32'(inf_v), 32'd0);
        check("st_progress", 32'(total > 1000), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
